dff_write_arbiter: RTL and testbench
====================================

// Module: dff_write_arbiter
// PURPOSE
//   Round-robin arbiter sharing one WIDTH-bit D-flip-flop register between NREQ requesters.
//   - Each write is one grant-and-capture transaction.
//   - Owns the register value (o_q) and reports transaction status.
//   - Sits between the requesting blocks and the register's downstream consumers.
// PARAMETERS
//   WIDTH      4        register / per-requester data width
//   NREQ       4        number of requesters (2..8)
//   GAP_CYCLES 0        idle cycles forced after each completed write (0..15)
//   RESET_VAL  0        value loaded into o_q on reset
// PORTS
//   i_clk      in   1            rising-edge clock
//   i_rst      in   1            asynchronous reset, active-high
//   i_req      in   NREQ         per-requester write request, level
//   i_data     in   NREQ*WIDTH   requester k data at [k*WIDTH +: WIDTH]
//   o_gnt      out  NREQ         registered one-hot grant, at most one bit set
//   o_owner    out  clog2(NREQ)  index of last/current granted requester
//   o_q        out  WIDTH        shared register contents
//   o_done     out  1            1-cycle pulse: write committed to o_q
//   o_abort    out  1            1-cycle pulse: grant withdrawn, no write
//   o_busy     out  1            state != IDLE
//   o_wr_cnt   out  8            committed-write counter, wraps 255->0
// BEHAVIOUR
//   Reset (async, i_rst=1, immediate):
//     - state=IDLE, o_q=RESET_VAL, o_gnt=0, o_owner=0, o_done=0, o_abort=0, o_wr_cnt=0.
//     - Priority pointer ptr=NREQ-1, so requester 0 wins first.
//     - Reset mid-transaction discards it; no done/abort pulse is generated.
//   FSM states: IDLE, GRANT, GAP.
//   IDLE, edge where i_req!=0:
//     - win = first set i_req bit searching ptr+1, ptr+2, ... modulo NREQ.
//     - o_gnt<=onehot(win), o_owner<=win, ->GRANT.
//     - If i_req==0: stay in IDLE, o_gnt stays 0.
//   GRANT, next edge, o_gnt cleared in all cases:
//     - i_req[o_owner]=1: o_q<=i_data slice of o_owner, o_done<=1, o_wr_cnt+=1, ptr<=o_owner.
//       Then ->GAP if GAP_CYCLES>0, else ->IDLE.
//     - i_req[o_owner]=0: o_q unchanged, o_abort<=1, ptr unchanged, ->IDLE.
//       Aborts never enter GAP.
//   GAP: 4-bit down-counter loaded with GAP_CYCLES-1 on entry; ->IDLE when it reaches 0.
//     - Requests are ignored while in GAP.
//   o_done/o_abort are high for exactly one cycle; they may overlap a new IDLE arbitration.
//   Latency, GAP_CYCLES=0:
//     - Request seen at edge E0: o_gnt high E0..E1, o_q/o_done valid after E1.
//     - Next grant may start at E2: max one write per 2 cycles.
//     - Generally, one write per 2+GAP_CYCLES cycles.
//   Fairness: a continuously requesting requester waits at most NREQ-1 other writes.
//   Changes to i_data during GRANT: the value present at the capture edge is stored.
//   o_owner holds its value after a transaction until the next grant.
// TESTING
//   1. Reset: i_rst=1 at t=2ns mid-cycle -> o_q=RESET_VAL, o_gnt=0, o_wr_cnt=0 without waiting for a clock edge.
//   2. Single write: i_req=4'b0100, slice2=4'hA -> o_gnt=4'b0100 for 1 cycle,
//      next cycle o_q=4'hA, o_done=1, o_owner=2, o_wr_cnt=1.
//   3. Round-robin: i_req=4'b1111 held, data k=k+1 -> owners granted 0,1,2,3,0.
//      o_q sequence 1,2,3,4,1; a write every 2 cycles.
//   4. Abort: i_req=4'b0010, drop i_req[1] during GRANT -> o_abort=1, o_q unchanged, o_wr_cnt unchanged.
//      Re-request -> requester 1 granted again.
//   5. GAP_CYCLES=3 with i_req=4'b0011 held -> writes spaced 5 cycles.
//      o_busy low for exactly one cycle between transactions.
//   6. Wrap: 256 writes -> o_wr_cnt returns to 0.
//      Assert o_gnt one-hot-or-zero on every cycle.

Source files
------------

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register between NREQ requesters.
// Each write is a grant cycle followed by a capture edge, with an optional idle gap afterwards.
module dff_write_arbiter #(
   parameter int                WIDTH      = 4,
   parameter int                NREQ       = 4,
   parameter int                GAP_CYCLES = 0,
   parameter logic [WIDTH-1:0]  RESET_VAL  = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NREQ-1:0]           i_req,
   input  logic [NREQ*WIDTH-1:0]     i_data,
   output logic [NREQ-1:0]           o_gnt,
   output logic [$clog2(NREQ)-1:0]   o_owner,
   output logic [WIDTH-1:0]          o_q,
   output logic                      o_done,
   output logic                      o_abort,
   output logic                      o_busy,
   output logic [7:0]                o_wr_cnt
);

   localparam int OWNW = $clog2(NREQ);
   localparam logic [3:0] GapLoad = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [OWNW-1:0]   owner_q, owner_d;
   logic [OWNW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;
   logic [7:0]        wrCnt_q, wrCnt_d;
   logic [3:0]        gapCnt_q, gapCnt_d;
   logic              winFound;
   logic [OWNW-1:0]   winIdx;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         ptr_q    <= OWNW'(NREQ - 1);
         data_q   <= RESET_VAL;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
         wrCnt_q  <= 8'd0;
         gapCnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         data_q   <= data_d;
         done_q   <= done_d;
         abort_q  <= abort_d;
         wrCnt_q  <= wrCnt_d;
         gapCnt_q <= gapCnt_d;
      end
   end

   // Search starts just past the last successful writer so every requester gets a turn.
   always_comb begin
      int idx;
      idx      = 0;
      winFound = 1'b0;
      winIdx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(ptr_q) + i) % NREQ;
         if (!winFound && i_req[idx]) begin
            winFound = 1'b1;
            winIdx   = OWNW'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      data_d   = data_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      wrCnt_d  = wrCnt_q;
      gapCnt_d = gapCnt_q;
      case (state_q)
         IDLE: begin
            if (winFound) begin
               gnt_d   = NREQ'(1) << winIdx;
               owner_d = winIdx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A requester that drops its request while granted forfeits the write.
            if (i_req[owner_q]) begin
               data_d  = i_data[owner_q*WIDTH +: WIDTH];
               done_d  = 1'b1;
               wrCnt_d = wrCnt_q + 8'd1;
               ptr_d   = owner_q;
               if (GAP_CYCLES > 0) begin
                  state_d  = GAP;
                  gapCnt_d = GapLoad;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               abort_d = 1'b1;
               state_d = IDLE;
            end
         end
         GAP: begin
            if (gapCnt_q == 4'd0) state_d = IDLE;
            else gapCnt_d = gapCnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_gnt    = gnt_q;
      o_owner  = owner_q;
      o_q      = data_q;
      o_done   = done_q;
      o_abort  = abort_q;
      o_busy   = (state_q != IDLE);
      o_wr_cnt = wrCnt_q;
   end

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter: one instance with no gap, one with a 3-cycle gap.
// Stimulus pushes expected done/abort events; negedge monitors pop and compare them.
module tb_dff_write_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  reqA, reqB;
   logic [15:0] dataA, dataB;
   logic [3:0]  gntA, gntB;
   logic [1:0]  ownerA, ownerB;
   logic [3:0]  qA, qB;
   logic        doneA, doneB, abortA, abortB, busyA, busyB;
   logic [7:0]  cntA, cntB;

   typedef struct {
      bit         isAbort;
      int         owner;
      logic [3:0] q;
      logic [7:0] cnt;
      int         gap;
   } exp_t;

   exp_t expQA[$];
   exp_t expQB[$];
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   int   lastDone[2];
   int   lowCnt;

   dff_write_arbiter #(.WIDTH(4), .NREQ(4), .GAP_CYCLES(0), .RESET_VAL(4'h0)) dutA (
      .i_clk(clk), .i_rst(rst), .i_req(reqA), .i_data(dataA),
      .o_gnt(gntA), .o_owner(ownerA), .o_q(qA), .o_done(doneA),
      .o_abort(abortA), .o_busy(busyA), .o_wr_cnt(cntA)
   );

   dff_write_arbiter #(.WIDTH(4), .NREQ(4), .GAP_CYCLES(3), .RESET_VAL(4'h0)) dutB (
      .i_clk(clk), .i_rst(rst), .i_req(reqB), .i_data(dataB),
      .o_gnt(gntB), .o_owner(ownerB), .o_q(qB), .o_done(doneB),
      .o_abort(abortB), .o_busy(busyB), .o_wr_cnt(cntB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle++;

   task automatic compare(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input int dut, input logic done, input logic abort,
                              input logic [1:0] owner, input logic [3:0] q, input logic [7:0] cnt);
      exp_t e;
      if ((dut == 0 && expQA.size() == 0) || (dut == 1 && expQB.size() == 0)) begin
         tests++;
         fails++;
         $display("[TB] FAIL unexpected_event dut%0d: got done=%0b abort=%0b, expected none", dut, done, abort);
         return;
      end
      if (dut == 0) e = expQA.pop_front();
      else e = expQB.pop_front();
      compare($sformatf("kind dut%0d", dut), int'({done, abort}), e.isAbort ? 1 : 2);
      compare($sformatf("owner dut%0d", dut), int'(owner), e.owner);
      compare($sformatf("q dut%0d", dut), int'(q), int'(e.q));
      compare($sformatf("wr_cnt dut%0d", dut), int'(cnt), int'(e.cnt));
      if (e.gap != 0) compare($sformatf("spacing dut%0d", dut), cycle - lastDone[dut], e.gap);
      if (done) lastDone[dut] = cycle;
   endtask

   // Monitors: grant shape every cycle, scoreboard pop on each completion pulse.
   always @(negedge clk) begin
      tests++;
      if (!$onehot0(gntA) || !$onehot0(gntB)) begin
         fails++;
         $display("[TB] FAIL onehot: got gntA=%b gntB=%b, expected one-hot-or-zero", gntA, gntB);
      end
      if (doneA || abortA) checkOutput(0, doneA, abortA, ownerA, qA, cntA);
      if (doneB || abortB) checkOutput(1, doneB, abortB, ownerB, qB, cntB);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      #3 rst = 1'b1;
      #4 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input int dut, input bit isAbort, input int owner,
                          input logic [3:0] q, input logic [7:0] cnt, input int gap);
      exp_t e;
      e.isAbort = isAbort;
      e.owner   = owner;
      e.q       = q;
      e.cnt     = cnt;
      e.gap     = gap;
      if (dut == 0) expQA.push_back(e);
      else expQB.push_back(e);
   endtask

   task automatic applyStimulus();
      // Asynchronous reset seen mid-cycle, before any clock edge.
      #2 rst = 1'b1;
      #1;
      compare("reset q", int'(qA), 0);
      compare("reset gnt", int'(gntA), 0);
      compare("reset wr_cnt", int'(cntA), 0);
      compare("reset busy", int'(busyA), 0);
      compare("reset qB", int'(qB), 0);
      #19 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single write from requester 2.
      dataA = 16'h0A00;
      reqA  = 4'b0100;
      pushExp(0, 0, 2, 4'hA, 8'd1, 0);
      tick(1);
      @(negedge clk);
      compare("single gnt", int'(gntA), 4'b0100);
      compare("single busy", int'(busyA), 1);
      @(posedge clk);
      #1;
      reqA = 4'b0000;
      tick(2);
      compare("single gnt cleared", int'(gntA), 0);

      // Round-robin with all four requesting.
      doReset();
      dataA = {4'd4, 4'd3, 4'd2, 4'd1};
      reqA  = 4'b1111;
      pushExp(0, 0, 0, 4'd1, 8'd1, 0);
      pushExp(0, 0, 1, 4'd2, 8'd2, 2);
      pushExp(0, 0, 2, 4'd3, 8'd3, 2);
      pushExp(0, 0, 3, 4'd4, 8'd4, 2);
      pushExp(0, 0, 0, 4'd1, 8'd5, 2);
      tick(10);
      reqA = 4'b0000;
      tick(2);

      // Abort by dropping the request while granted, then re-request with data changed mid-grant.
      reqA = 4'b0010;
      tick(1);
      reqA = 4'b0000;
      pushExp(0, 1, 1, 4'd1, 8'd5, 0);
      @(negedge clk);
      compare("abort gnt", int'(gntA), 4'b0010);
      @(posedge clk);
      #1;
      reqA = 4'b0010;
      tick(1);
      dataA[7:4] = 4'h7;
      pushExp(0, 0, 1, 4'h7, 8'd6, 0);
      @(negedge clk);
      compare("regrant gnt", int'(gntA), 4'b0010);
      @(posedge clk);
      #1;
      reqA = 4'b0000;
      tick(2);

      // Gap of three idle cycles between writes.
      dataB = {8'h00, 4'h9, 4'h5};
      reqB  = 4'b0011;
      pushExp(1, 0, 0, 4'h5, 8'd1, 0);
      pushExp(1, 0, 1, 4'h9, 8'd2, 5);
      pushExp(1, 0, 0, 4'h5, 8'd3, 5);
      pushExp(1, 0, 1, 4'h9, 8'd4, 5);
      tick(1);
      lowCnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!busyB) lowCnt++;
      end
      compare("gap busy-low cycles", lowCnt, 3);
      @(posedge clk);
      #1;
      reqB = 4'b0000;
      tick(6);

      // 256 writes wrap the counter back to zero.
      doReset();
      dataA = 16'h0003;
      reqA  = 4'b0001;
      for (int i = 0; i < 256; i++) pushExp(0, 0, 0, 4'h3, 8'(i + 1), (i == 0) ? 0 : 2);
      tick(512);
      reqA = 4'b0000;
      tick(2);
      compare("wrap wr_cnt", int'(cntA), 0);
      compare("wrap q", int'(qA), 3);

      compare("scoreboard A drained", expQA.size(), 0);
      compare("scoreboard B drained", expQB.size(), 0);
   endtask

   initial begin
      rst   = 1'b0;
      reqA  = '0;
      reqB  = '0;
      dataA = '0;
      dataB = '0;
      lastDone[0] = 0;
      lastDone[1] = 0;
      applyStimulus();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
